segre_mem_arbiter: RTL and testbench

Parametrised main-memory arbiter that generalises the two-port (I$/D$) cache-to-memory path to NUM_CH requesters. It uses round-robin arbitration, issues one transaction at a time, and routes the response back to the winning channel. It sits between the cache controllers and the main-memory interface of segre_core.

---
 rtl/segre_pkg.sv | 21 ++
 rtl/segre_rr_picker.sv | 32 +++
 rtl/segre_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared segre core types: memory op sizes and main-memory arbiter states.
// Also provides the channel-index width helper used by the arbiter.
package segre_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } mem_arb_state_e;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/segre_rr_picker.sv
// Combinational round-robin picker: first masked request at or above ptr_i,
// wrapping to 0.
module segre_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] eff;

  assign eff = req_i & mask_i;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && eff[j]) begin
        valid_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Round-robin main-memory arbiter for NUM_CH cache requesters, one transaction
// at a time. Define SEGRE_MEM_ARB_RD_PRIO_EN to favour reads over writes.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LANE_W = 128
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        wr_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*WORD_W-1:0] wr_data_i,
  input  logic [NUM_CH*2-1:0]      wr_type_i,
  output logic [NUM_CH-1:0]        gnt_o,
  output logic [NUM_CH-1:0]        rdy_o,
  output logic [LANE_W-1:0]        rd_data_o,
  output logic                     mm_rd_o,
  output logic                     mm_wr_o,
  output logic [ADDR_W-1:0]        mm_addr_o,
  output logic [WORD_W-1:0]        mm_wr_data_o,
  output logic [1:0]               mm_wr_data_type_o,
  input  logic                     mm_data_rdy_i,
  input  logic [LANE_W-1:0]        mm_rd_data_i
);

  localparam int IW = ch_idx_w(NUM_CH);

  mem_arb_state_e    state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     w_q, w_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [NUM_CH-1:0] rdy_q, rdy_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdat_q, wdat_d;
  logic [1:0]        wtyp_q, wtyp_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  logic [NUM_CH-1:0] mask;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;

`ifdef SEGRE_MEM_ARB_RD_PRIO_EN
  // Reads stall the core on a miss, so they bypass pending writes.
  assign mask = (|(req_i & ~wr_i)) ? ~wr_i : '1;
`else
  assign mask = '1;
`endif

  segre_rr_picker #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_picker (
    .req_i   (req_i),
    .mask_i  (mask),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    gnt_d   = '0;
    rdy_d   = '0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wtyp_d  = wtyp_q;
    lane_d  = lane_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          w_d     = pick_idx;
          rd_d    = ~wr_i[pick_idx];
          wr_d    = wr_i[pick_idx];
          addr_d  = addr_i[pick_idx*ADDR_W +: ADDR_W];
          wdat_d  = wr_data_i[pick_idx*WORD_W +: WORD_W];
          wtyp_d  = wr_type_i[pick_idx*2 +: 2];
          gnt_d   = NUM_CH'(1) << pick_idx;
          ptr_d   = (pick_idx == IW'(NUM_CH - 1)) ? '0 : pick_idx + IW'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mm_data_rdy_i) begin
          lane_d  = mm_rd_data_i;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rdy_d   = NUM_CH'(1) << w_q;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      gnt_q   <= '0;
      rdy_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wtyp_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      gnt_q   <= gnt_d;
      rdy_q   <= rdy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wtyp_q  <= wtyp_d;
      lane_q  <= lane_d;
    end
  end

  assign gnt_o             = gnt_q;
  assign rdy_o             = rdy_q;
  assign rd_data_o         = lane_q;
  assign mm_rd_o           = rd_q;
  assign mm_wr_o           = wr_q;
  assign mm_addr_o         = addr_q;
  assign mm_wr_data_o      = wdat_q;
  assign mm_wr_data_type_o = wtyp_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Randomised bench for segre_mem_arbiter with a transaction-level model.
// Three channels so pointer wrap and strict rotation are exercised.
module tb_segre_mem_arbiter;

  localparam int NC = 3;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int LW = 128;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    req, wr;
  logic [NC*AW-1:0] addr;
  logic [NC*WW-1:0] wdata;
  logic [NC*2-1:0]  wtype;
  logic [NC-1:0]    gnt, rdy;
  logic [LW-1:0]    rd_data;
  logic             mm_rd, mm_wr;
  logic [AW-1:0]    mm_addr;
  logic [WW-1:0]    mm_wdata;
  logic [1:0]       mm_wtype;
  logic             mm_rdy;
  logic [LW-1:0]    mm_rdata;

  segre_mem_arbiter #(
    .NUM_CH (NC),
    .ADDR_W (AW),
    .WORD_W (WW),
    .LANE_W (LW)
  ) dut (
    .clk_i             (clk),
    .rsn_i             (rst),
    .req_i             (req),
    .wr_i              (wr),
    .addr_i            (addr),
    .wr_data_i         (wdata),
    .wr_type_i         (wtype),
    .gnt_o             (gnt),
    .rdy_o             (rdy),
    .rd_data_o         (rd_data),
    .mm_rd_o           (mm_rd),
    .mm_wr_o           (mm_wr),
    .mm_addr_o         (mm_addr),
    .mm_wr_data_o      (mm_wdata),
    .mm_wr_data_type_o (mm_wtype),
    .mm_data_rdy_i     (mm_rdy),
    .mm_rd_data_i      (mm_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester-side view: who is asking, and with what payload.
  logic [NC-1:0] pend;
  logic          pw [NC];
  logic [AW-1:0] pa [NC];
  logic [WW-1:0] pd [NC];
  logic [1:0]    pt [NC];

  task automatic new_req(input int c);
    pend[c] = 1'b1;
    pw[c]   = 1'($urandom_range(0, 1));
    pa[c]   = $urandom;
    pd[c]   = $urandom;
    pt[c]   = 2'($urandom_range(0, 2));
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      req[i]            = pend[i];
      wr[i]             = pw[i];
      addr[i*AW +: AW]  = pa[i];
      wdata[i*WW +: WW] = pd[i];
      wtype[i*2 +: 2]   = pt[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: scan channels ptr, ptr+1, ... modulo NC.
  function automatic int pick(input logic [NC-1:0] p, input int ptr);
    logic [NC-1:0] cand;
    cand = p;
`ifdef SEGRE_MEM_ARB_RD_PRIO_EN
    for (int i = 0; i < NC; i++)
      if (p[i] && !pw[i]) cand = '0;
    if (cand == '0)
      for (int i = 0; i < NC; i++) cand[i] = p[i] && !pw[i];
`endif
    for (int k = 0; k < NC; k++)
      if (cand[(ptr + k) % NC]) return (ptr + k) % NC;
    return -1;
  endfunction

  initial begin
    int            ptr, w, d;
    logic          ewr;
    logic [AW-1:0] ea;
    logic [WW-1:0] ed;
    logic [1:0]    et;
    logic [LW-1:0] lane;
    logic [NC-1:0] oh;

    rst = 1'b1; mm_rdy = 1'b0; mm_rdata = '0;
    pend = '0;
    for (int i = 0; i < NC; i++) begin
      pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; pt[i] = '0;
    end
    drive();
    step(); step();
    check("rst_gnt", LW'(gnt), '0);
    check("rst_rdy", LW'(rdy), '0);
    check("rst_mm_rd", LW'(mm_rd), '0);
    check("rst_mm_wr", LW'(mm_wr), '0);
    check("rst_addr", LW'(mm_addr), '0);
    check("rst_wdata", LW'(mm_wdata), '0);
    check("rst_wtype", LW'(mm_wtype), '0);
    check("rst_rd_data", rd_data, '0);
    rst = 1'b0;
    ptr = 0;

    for (int t = 0; t < 80; t++) begin
      if (t < 8) begin
        for (int i = 0; i < NC; i++) if (!pend[i]) new_req(i);
      end else if (t % 7 != 3) begin
        for (int i = 0; i < NC; i++)
          if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      end

      if (pend == '0) begin
        drive();
        mm_rdy = 1'b1;
        step();
        check("idle_gnt", LW'(gnt), '0);
        check("idle_rdy", LW'(rdy), '0);
        check("idle_mm_rd", LW'({mm_rd, mm_wr}), '0);
        continue;
      end

      w = pick(pend, ptr);
      oh = NC'(1) << w;
      ewr = pw[w]; ea = pa[w]; ed = pd[w]; et = pt[w];
      drive();
      mm_rdy = 1'($urandom_range(0, 1));
      step();
      check("gnt", LW'(gnt), LW'(oh));
      check("rdy_busy", LW'(rdy), '0);
      check("mm_rd", LW'(mm_rd), LW'(!ewr));
      check("mm_wr", LW'(mm_wr), LW'(ewr));
      check("mm_addr", LW'(mm_addr), LW'(ea));
      if (ewr) begin
        check("mm_wdata", LW'(mm_wdata), LW'(ed));
        check("mm_wtype", LW'(mm_wtype), LW'(et));
      end
      ptr = (w + 1) % NC;

      pend[w] = 1'b0;
      if (t < 8 || $urandom_range(0, 1) == 1) new_req(w);
      else begin
        pa[w] = $urandom; pd[w] = $urandom;
      end
      drive();

      if (t == 20) begin
        rst = 1'b1;
        mm_rdy = 1'b1;
        step();
        check("rstb_mm", LW'({mm_rd, mm_wr}), '0);
        check("rstb_gnt", LW'(gnt), '0);
        check("rstb_rdy", LW'(rdy), '0);
        rst = 1'b0;
        if (!pend[w]) begin
          pend[w] = 1'b1; pw[w] = ewr; pa[w] = ea; pd[w] = ed; pt[w] = et;
        end
        req = '0;
        step();
        check("rsta_rdy", LW'(rdy), '0);
        check("rsta_gnt", LW'(gnt), '0);
        ptr = 0;
        continue;
      end

      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        mm_rdy = 1'b0;
        step();
        check("busy_gnt", LW'(gnt), '0);
        check("busy_rdy", LW'(rdy), '0);
        check("busy_mm", LW'({mm_rd, mm_wr}), LW'({!ewr, ewr}));
        check("busy_addr", LW'(mm_addr), LW'(ea));
      end

      mm_rdy = 1'b1;
      lane = {$urandom, $urandom, $urandom, $urandom};
      mm_rdata = lane;
      step();
      check("resp_rdy", LW'(rdy), LW'(oh));
      check("resp_gnt", LW'(gnt), '0);
      check("resp_mm", LW'({mm_rd, mm_wr}), '0);
      if (!ewr) check("resp_lane", rd_data, lane);

      mm_rdy = 1'($urandom_range(0, 1));
      mm_rdata = {$urandom, $urandom, $urandom, $urandom};
      step();
      check("post_rdy", LW'(rdy), '0);
      check("post_gnt", LW'(gnt), '0);
      if (!ewr) check("post_lane", rd_data, lane);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
